// File: rtl/add_pipe.sv
// Carry-segmented pipelined adder: one CW-bit chunk of the sum is resolved per rank, with valid/ready flow control.
// Optional macro ADD_PIPE_OUTPUT_FLOPS_EN adds a registered output rank after the final chunk add.
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = WIDTH / STAGES;

    // Handshake: a transfer happens at a rising edge where valid && ready.
    // A rank is ready when it is empty or the rank after it is ready.
    // Ready is purely combinational from out_ready back to in_ready.

    // x_q[r] packs resolved sum chunks (top r chunks) above the remaining A
    // chunks, so the A chunk for rank r always sits in bits [CW-1:0].
    logic [WIDTH-1:0] x_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic             cy_q [STAGES];
    logic             v_q  [STAGES];

    logic [CW:0]      ch   [STAGES];
    logic             rdy  [STAGES+1];
    logic             ready_last;
    logic [WIDTH-1:0] c_comb;
    logic             co_comb;

    always_comb begin
        for (int r = 0; r < STAGES; r++) begin
            ch[r] = {1'b0, x_q[r][CW-1:0]} + {1'b0, b_q[r][CW-1:0]} + {{CW{1'b0}}, cy_q[r]};
        end
        c_comb  = (x_q[STAGES-1] >> CW) | (WIDTH'(ch[STAGES-1][CW-1:0]) << (WIDTH - CW));
        co_comb = ch[STAGES-1][CW];
        rdy[STAGES] = ready_last;
        for (int r = STAGES - 1; r >= 0; r--) begin
            rdy[r] = !v_q[r] || rdy[r+1];
        end
    end

    assign in_ready = rdy[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < STAGES; r++) begin
                v_q[r]  <= 1'b0;
                x_q[r]  <= '0;
                b_q[r]  <= '0;
                cy_q[r] <= 1'b0;
            end
        end else begin
            if (rdy[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    x_q[0]  <= a;
                    b_q[0]  <= b;
                    cy_q[0] <= 1'b0;
                end
            end
            for (int r = 1; r < STAGES; r++) begin
                if (rdy[r]) begin
                    v_q[r] <= v_q[r-1];
                    if (v_q[r-1]) begin
                        // Shift the freshly resolved chunk in at the top.
                        x_q[r]  <= (x_q[r-1] >> CW) | (WIDTH'(ch[r-1][CW-1:0]) << (WIDTH - CW));
                        b_q[r]  <= b_q[r-1] >> CW;
                        cy_q[r] <= ch[r-1][CW];
                    end
                end
            end
        end
    end

`ifdef ADD_PIPE_OUTPUT_FLOPS_EN
    logic             o_v;
    logic [WIDTH-1:0] o_c;
    logic             o_co;

    assign ready_last = !o_v || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_v  <= 1'b0;
            o_c  <= '0;
            o_co <= 1'b0;
        end else if (ready_last) begin
            o_v <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
                o_c  <= c_comb;
                o_co <= co_comb;
            end
        end
    end

    assign out_valid = o_v;
    assign c         = o_c;
    assign carry_out = o_co;
`else
    assign ready_last = out_ready;
    assign out_valid  = v_q[STAGES-1];
    assign c          = c_comb;
    assign carry_out  = co_comb;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: random operands scored against a plain a+b model with an
// in-flight queue; covers carry ripple, streaming, backpressure, bubbles, async reset and STAGES=1.
module tb_add_pipe;
    localparam int W = 32;
    localparam int S = 4;
`ifdef ADD_PIPE_OUTPUT_FLOPS_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif
    localparam int CAP   = S + XTRA;
    localparam int LAT_E = S - 1 + XTRA;  // edges after the accepting edge

    logic         clk, rst;
    logic [W-1:0] a, b, c;
    logic         in_valid, in_ready, carry_out, out_valid, out_ready;

    logic [W-1:0] a1, b1, c1;
    logic         v1, rdy1, co1, ov1;

    int           n_checks, n_errors, cyc;
    logic [W:0]   exp_q[$];
    int           acc_q[$];
    bit           lat_chk;

    add_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .c(c), .carry_out(carry_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    add_pipe #(.WIDTH(W), .STAGES(1)) u_one (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1), .in_ready(rdy1),
        .c(c1), .carry_out(co1), .out_valid(ov1), .out_ready(1'b1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus plus scoreboard work for the main DUT.
    task automatic cycle(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ordy, output bit acc);
        @(negedge clk);
        in_valid  = v;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, (exp_q.size() < CAP) || ordy);
        if (exp_q.size() == 0) chk("out_valid_empty", out_valid, 0);
        else if (out_valid) begin
            chk("sum", {carry_out, c}, exp_q[0]);
            if (ordy) begin
                if (lat_chk) chk("latency", cyc - acc_q[0], LAT_E);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
        end
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back({1'b0, av} + {1'b0, bv});
            acc_q.push_back(cyc + 1);
        end
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            n++;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        bit           acc;
        int           idx, nacc;
        logic [W-1:0] ra [5];
        logic [W-1:0] rb [5];

        n_checks = 0; n_errors = 0; cyc = 0; lat_chk = 0;
        rst = 1'b1; in_valid = 0; a = '0; b = '0; out_ready = 0;
        v1 = 0; a1 = '0; b1 = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rst = 1'b0;

        // carry ripple through every chunk, then a mid-chunk carry pattern
        lat_chk = 1;
        cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, acc);
        chk("ripple_acc", acc, 1);
        cycle(1'b1, 32'h00FF_00FF, 32'h0001_0001, 1'b1, acc);
        while (exp_q.size() > 1 && cyc < 60) cycle(1'b0, '0, '0, 1'b1, acc);
        chk("ripple_sum2_const", exp_q[0], 33'h0_0100_0100);
        drain();

        // streaming
        for (int i = 0; i < 16; i++) cycle(1'b1, $urandom(), $urandom(), 1'b1, acc);
        drain();
        lat_chk = 0;

        // backpressure: five offers against a stalled output
        for (int i = 0; i < 5; i++) begin ra[i] = $urandom(); rb[i] = $urandom(); end
        idx = 0; nacc = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(idx < 5, ra[idx % 5], rb[idx % 5], 1'b0, acc);
            if (acc) begin idx++; nacc++; end
        end
        chk("bp_accepted", nacc, (CAP < 5) ? CAP : 5);
        while (idx < 5 && cyc < 400) begin
            cycle(1'b1, ra[idx], rb[idx], 1'b1, acc);
            if (acc) idx++;
        end
        drain();

        // bubble collapse
        cycle(1'b1, $urandom(), $urandom(), 1'b0, acc);
        cycle(1'b0, '0, '0, 1'b0, acc);
        cycle(1'b0, '0, '0, 1'b0, acc);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom(), $urandom(), 1'b0, acc);
            chk("bubble_acc", acc, 1);
        end
        cycle(1'b0, '0, '0, 1'b0, acc);
        chk("bubble_held_valid", out_valid, 1);
        drain();

        // async reset with three operations in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom(), $urandom(), 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_c", c, 0);
        chk("arst_carry", carry_out, 0);
        chk("arst_in_ready", in_ready, 1);
        exp_q.delete();
        acc_q.delete();
        #10;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b1, acc);

        // single-rank instance
        @(negedge clk);
        a1 = 32'h8000_0000; b1 = 32'h8000_0000; v1 = 1'b1;
        #1 chk("one_in_ready", rdy1, 1);
        chk("one_pre_valid", ov1, 0);
        @(negedge clk);
        v1 = 1'b0;
        repeat (XTRA) @(negedge clk);
        #1;
        chk("one_valid", ov1, 1);
        chk("one_c", c1, 0);
        chk("one_carry", co1, 1);
        @(negedge clk);
        #1 chk("one_valid_drop", ov1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, carry-segmented pipelined adder with valid/ready flow control. It splits a WIDTH-bit add into STAGES equal chunks, resolving one chunk per pipeline rank, and stalls or collapses bubbles under downstream backpressure. It is the general replacement for the single-rank, valid-only add wrapper. With STAGES=1 and out_ready tied high, its cycle behaviour matches that wrapper.

## Interface
- WIDTH, 32: operand and sum width; must be a multiple of STAGES.
- STAGES, 4: number of register ranks and of sum chunks, ≥1; chunk width CW = WIDTH/STAGES.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- c  out  WIDTH  sum, modulo 2^WIDTH.
- carry_out  out  1  carry out of bit WIDTH-1.
- out_valid  out  1  c/carry_out valid.
- out_ready  in  1  downstream accepts result.

## Operation
- Ranks r=0..STAGES-1, each with valid_r.
- Rank 0 captures full a, b.
- Rank r≥1 holds:
  - sum chunks 0..r-1, already resolved;
  - carry into chunk r;
  - operand chunks r..STAGES-1.
- Between rank r-1 and rank r, combinational logic adds chunk r-1 plus the incoming carry. The carry into chunk 0 is 0.
- Chunk STAGES-1 is added combinationally after the last rank and drives c and carry_out. There are no output flops unless the macro below is defined.
- Flow control:
  - ready_last = out_ready.
  - ready_r = !valid_r || ready_{r+1}.
  - in_ready = ready_0.
- On each edge, when ready_r is 1:
  - valid_r <= valid_{r-1}, with valid_{-1} = in_valid;
  - data regs load only if the incoming valid is also 1;
  - otherwise data regs hold.
- When ready_r is 0, rank r holds data and valid.
- Bubbles collapse: an empty rank accepts new data even while downstream ranks are stalled.
- A transfer occurs at the edge where valid && ready, at both the input and the output.
- Ready is a combinational chain from out_ready to in_ready, with no register in the path.
- Reset (async assert, release synchronous to clk):
  - all valid_r = 0;
  - all data, partial-sum and carry regs = 0.
- Reset values of outputs:
  - out_valid = 0, c = 0, carry_out = 0;
  - in_ready = 1, which follows from ready_r = !valid_r.
- Reset mid-operation discards all in-flight operations without emitting them.
- Arithmetic:
  - each chunk produces CW+1 bits, of which the MSB is the carry;
  - the final chunk's carry is carry_out;
  - overflow wraps.

## Timing
- Latency: an input accepted at edge t gives out_valid=1 in the cycle after edge t+STAGES-1, i.e. STAGES edges with no stall.
  - STAGES=1: result is visible the cycle after acceptance.
- Throughput: one result per cycle while out_ready=1.
- Stall: with out_ready=0, the pipeline fills to STAGES entries and then in_ready=0 in the same cycle.
- Releasing out_ready=1 restores in_ready=1 combinationally in that cycle.
- The output holds stable (c, carry_out, out_valid) while out_valid=1 and out_ready=0.
- Simultaneous input accept and output drain on a full pipe is legal; occupancy stays constant.

## Configuration
- ADD_PIPE_OUTPUT_FLOPS_EN defined:
  - adds a rank after the final chunk add, registering c, carry_out and out_valid;
  - it uses the same ready rule, with ready_last applied to the new rank;
  - latency becomes STAGES+1 and capacity STAGES+1;
  - c and carry_out come straight from flops.
- Undefined: c and carry_out are combinational from rank STAGES-1, as described above.

## Test plan
- Carry ripple (WIDTH=32, STAGES=4, out_ready=1): a=0xFFFFFFFF, b=0x00000001 -> c=0x00000000, carry_out=1, out_valid exactly 4 edges after acceptance. Then a=0x00FF00FF, b=0x00010001 -> c=0x01000100, carry_out=0.
- Streaming: 16 back-to-back random pairs, out_ready=1 -> in_ready constantly 1; 16 results in order, one per cycle; sums match the reference model.
- Backpressure: out_ready=0 while 5 inputs are offered -> 4 are accepted, then in_ready=0. c stays stable for the oldest result. Raising out_ready -> all 4 results drain in order, followed by the 5th.
- Bubble collapse: one input, idle 2 cycles, out_ready=0, then 3 inputs -> all 3 accepted without in_ready dropping. The first is still held at the output.
- Async reset mid-flight: rst asserted between edges with 3 ops in flight -> out_valid=0, c=0, carry_out=0, in_ready=1 immediately. No stale result after release.
- STAGES=1, WIDTH=32, out_ready=1: a=0x80000000, b=0x80000000 -> next cycle c=0, carry_out=1, out_valid=1. With ADD_PIPE_OUTPUT_FLOPS_EN, the same result arrives one cycle later.
